// File: rtl/spi_master_cfg_if.sv
// Front-end handshake bundle for spi_master_cfg: transfer request, per-transfer
// configuration and completion/result signals.
interface spi_master_cfg_if #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8
);
    localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

    logic              start;
    logic              ready;
    logic [DATA_W-1:0] tx_data;
    logic [SS_W-1:0]   ss_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (
        output start, tx_data, ss_sel, cpol, cpha, lsb_first, clk_div,
        input  ready, rx_data, rx_valid
    );

    modport slave (
        input  start, tx_data, ss_sel, cpol, cpha, lsb_first, clk_div,
        output ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: per-transfer mode, bit order, SCLK divider, one-of-N select.
// Define SPI_MASTER_LOOPBACK_EN to add the loopback port (rx samples internal mosi).
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_cfg_if.slave   bus,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic              loopback
`endif
);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_rx_valid;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_SS-1:0] r_ss_n;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_clk_div;
    logic [EDGE_W-1:0] r_edge;
    logic              r_cpha;
    logic              r_lsb;

    logic              w_tick;
    logic              w_leading;
    logic              w_sample;
    logic              w_shift;
    logic              w_next_bit;
    logic              w_miso;
    logic [DATA_W-1:0] w_tx_shifted;
    logic [DATA_W-1:0] w_rx_shifted;
    logic [NUM_SS-1:0] w_ss_dec;

    // r_edge counts SCLK edges already issued, so even values mean the next edge is leading.
    assign w_tick     = (r_div == r_clk_div);
    assign w_leading  = ~r_edge[0];
    assign w_sample   = w_leading ^ r_cpha;
    assign w_shift    = r_cpha ? (w_leading && (r_edge != '0))
                               : (!w_leading && (r_edge != LAST_EDGE));
    assign w_next_bit = r_lsb ? r_tx_sh[1] : r_tx_sh[DATA_W-2];
    assign w_tx_shifted = r_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
    assign w_rx_shifted = r_lsb ? {w_miso, r_rx_sh[DATA_W-1:1]}
                                : {r_rx_sh[DATA_W-2:0], w_miso};

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_miso = loopback ? r_mosi : miso;
`else
    assign w_miso = miso;
`endif

    // Out-of-range selects decode to no active line; the transfer still runs.
    always_comb begin
        w_ss_dec = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (32'(bus.ss_sel) == i) begin
                w_ss_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= '1;
            r_rx_data  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_div      <= '0;
            r_clk_div  <= '0;
            r_edge     <= '0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rx_valid <= 1'b0;
                    r_sclk     <= bus.cpol;
                    r_mosi     <= 1'b0;
                    if (bus.start) begin
                        r_state   <= S_LEAD;
                        r_ready   <= 1'b0;
                        r_ss_n    <= w_ss_dec;
                        r_tx_sh   <= bus.tx_data;
                        r_mosi    <= bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
                        r_rx_sh   <= '0;
                        r_cpha    <= bus.cpha;
                        r_lsb     <= bus.lsb_first;
                        r_clk_div <= bus.clk_div;
                        r_div     <= '0;
                        r_edge    <= '0;
                    end
                end
                // LEAD ends with SCLK edge 1, so it shares the edge logic with XFER.
                S_LEAD, S_XFER: begin
                    if (w_tick) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + 1'b1;
                        if (w_sample) begin
                            r_rx_sh <= w_rx_shifted;
                        end
                        if (w_shift) begin
                            r_tx_sh <= w_tx_shifted;
                            r_mosi  <= w_next_bit;
                        end
                        r_state <= (r_edge == LAST_EDGE) ? S_TRAIL : S_XFER;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_div      <= '0;
                        r_state    <= S_IDLE;
                        r_ss_n     <= '1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_ready    <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready    = r_ready;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign sclk         = r_sclk;
    assign mosi         = r_mosi;
    assign ss_n         = r_ss_n;
endmodule
